tft_frame_decoder: RTL and testbench
====================================

# tft_frame_decoder

Receive-side decoder for the board LCD stream. Consumes the pixel bus (R, G, B, den, vsync) driven by the board display path, tracks active-area pixel coordinates, and samples one pixel per 10x10 grid intersection. Each sample is classified as white stone, black stone or empty, and the result is rebuilt into `board_state` / `turn_map` vectors in the same bit layout the board logic produces. It serves as a loop-back checker in the verification bench and on hardware debug builds.

## Interface
Parameters:
- `MAP_N`, 10: stones per row and column; output vectors are `MAP_N*MAP_N` bits.
- `H_ACTIVE`, 800: den-high pixels per line.
- `V_ACTIVE`, 480: den-active lines per frame.
- `CX0`, 240: active-area x of the col-0 intersection.
- `CY0`, 40: active-area y of the row-0 intersection.
- `PITCH`, 40: grid spacing in pixels.
- `SOFF`, 5: sample offset added to both x and y, so the sample lands off the black grid line.
- `WHI`, 8'hC0: white threshold; a pixel is white when R, G and B are all >= WHI.
- `BLO`, 8'h3F: black threshold; a pixel is black when R, G and B are all <= BLO.

Ports (clock and reset first):
- `clk` in 1: pixel clock, same as the display dclk.
- `rst` in 1: reset, asynchronous, active-high.
- `R`, `G`, `B` in 8 each: pixel colour, valid while den=1.
- `den` in 1: data enable.
- `vsync` in 1: frame sync, active-low.
- `board_state` out 100: bit k=row*MAP_N+col is 1 when a stone is present.
- `turn_map` out 100: bit k is 1 for white, 0 for black or empty.
- `frame_valid` out 1: one-cycle pulse when the outputs update.
- `frame_err` out 1: one-cycle pulse when a frame is discarded.
- `err_sticky` out 1: latched error; cleared only by rst.
- `frame_cnt` out 16: count of published frames, wraps.

## Operation
- The FSM has three states: SYNC, ACTIVE, CHECK. After reset it is in SYNC.
- SYNC: wait until vsync=0 is sampled. The first vsync=0 cycle clears x, y, the shadow vectors and the per-frame error bit, then moves to ACTIVE. Remain in SYNC while vsync stays low.
- ACTIVE:
  - x counts cycles with den=1 and returns to 0 on the den falling edge.
  - At each den falling edge, y increments and the line length x is compared with H_ACTIVE; a mismatch sets the per-frame error.
  - Sample condition: den=1, (x-CX0-SOFF)%PITCH==0, (y-CY0-SOFF)%PITCH==0, and col and row both < MAP_N, where col=(x-CX0-SOFF)/PITCH and row=(y-CY0-SOFF)/PITCH. Comparisons are unsigned on 11-bit x and 10-bit y. Coordinates below the origin produce no sample.
  - Classification of a sample:
    - white: shadow_state[k]=1, shadow_turn[k]=1.
    - black: shadow_state[k]=1, shadow_turn[k]=0.
    - otherwise (empty): both bits 0.
  - Leave ACTIVE for CHECK on the next vsync=0.
  - If y exceeds V_ACTIVE, set the per-frame error and keep counting.
- CHECK (one cycle):
  - If y==V_ACTIVE and there is no error: copy the shadow vectors to the outputs, pulse frame_valid and increment frame_cnt.
  - Otherwise: keep the outputs unchanged, pulse frame_err and set err_sticky.
  - Then re-enter SYNC, which restarts a frame because vsync is still low.
- vsync held low across many cycles counts as a single frame boundary.
- den=1 while vsync=0 is ignored; no counting or sampling takes place.

## Timing
- Reset values: board_state=0, turn_map=0, frame_valid=0, frame_err=0, err_sticky=0, frame_cnt=0; FSM in SYNC.
- All inputs are sampled on the rising edge of clk. A sample is written to the shadow vector at the same edge on which the qualifying pixel is seen.
- Publish latency: outputs and frame_valid change 2 cycles after the first vsync=0 sample (edge 1: enter CHECK; edge 2: publish).
- frame_valid and frame_err are mutually exclusive, each high for exactly one cycle.
- frame_cnt wraps from 16'hFFFF to 0.
- Reset asserted mid-frame: all state clears immediately, and the partially captured frame is never published.
- The first frame after reset is always discarded, because its start is unknown. Its CHECK is skipped silently: no frame_err pulse.

## Configuration
- `TFT_FRAME_DECODER_ERRCHK_EN` defined: line-length and line-count checks are active; failing frames are discarded and signalled as described above.
- Macro not defined: no length or count checks. Every frame reaching CHECK is published, frame_err and err_sticky are tied 0, and the line-length comparator is not built.

## Test plan
- Empty board frame (wood colour CD/85/3F at all samples) → frame_valid pulse, board_state=0, turn_map=0, frame_cnt=1 on the second frame after reset.
- White stone drawn at k=44 and black stone at k=0 → board_state bits 0 and 44 set, turn_map bit 44=1 and bit 0=0.
- One line in the frame has 799 den-high cycles (errchk build) → frame_err pulse, err_sticky=1, outputs hold the previous frame, frame_cnt unchanged.
- Frame with 481 active lines → frame_err pulse; the next good frame publishes normally with err_sticky still 1.
- rst pulsed at line 200 → all outputs 0 immediately; the first full frame after reset is not published and the second is published.
- vsync held low for 10 cycles → exactly one CHECK and one frame_valid pulse, 2 cycles after the first low sample.

Source files
------------

// File: rtl/tft_frame_decoder_if.sv
// Pixel-bus and decoded-board bundle for tft_frame_decoder.
// master: the side that drives the LCD pixel stream and observes the result.
// slave : the decoder itself.
interface tft_frame_decoder_if #(
  parameter int MAP_N = 10
);
  logic [7:0]             R;
  logic [7:0]             G;
  logic [7:0]             B;
  logic                   den;
  logic                   vsync;
  logic [MAP_N*MAP_N-1:0] board_state;
  logic [MAP_N*MAP_N-1:0] turn_map;
  logic                   frame_valid;
  logic                   frame_err;
  logic                   err_sticky;
  logic [15:0]            frame_cnt;

  modport master (
    output R, G, B, den, vsync,
    input  board_state, turn_map, frame_valid, frame_err, err_sticky, frame_cnt
  );

  modport slave (
    input  R, G, B, den, vsync,
    output board_state, turn_map, frame_valid, frame_err, err_sticky, frame_cnt
  );
endinterface

// File: rtl/tft_frame_decoder.sv
// tft_frame_decoder: loop-back decoder for the board LCD stream.
// Tracks active-area pixel coordinates, samples one pixel per grid
// intersection, classifies it as white / black / empty and rebuilds the
// board_state / turn_map vectors, publishing them once per good frame.
// Optional feature macro: TFT_FRAME_DECODER_ERRCHK_EN enables the
// line-length and line-count checks (frame_err / err_sticky); without it
// every frame reaching CHECK is published and the error outputs are 0.
module tft_frame_decoder #(
  parameter int         MAP_N    = 10,
  parameter int         H_ACTIVE = 800,
  parameter int         V_ACTIVE = 480,
  parameter int         CX0      = 240,
  parameter int         CY0      = 40,
  parameter int         PITCH    = 40,
  parameter int         SOFF     = 5,
  parameter logic [7:0] WHI      = 8'hC0,
  parameter logic [7:0] BLO      = 8'h3F
) (
  input logic             clk,
  input logic             rst,
  tft_frame_decoder_if.slave bus
);

  localparam int          N_CELLS = MAP_N * MAP_N;
  localparam int          K_W     = $clog2(N_CELLS);
  localparam logic [10:0] X_ORG   = 11'(CX0 + SOFF);
  localparam logic [9:0]  Y_ORG   = 10'(CY0 + SOFF);
  localparam logic [10:0] X_PITCH = 11'(PITCH);
  localparam logic [9:0]  Y_PITCH = 10'(PITCH);
  localparam logic [10:0] X_LIM   = 11'(H_ACTIVE);
  localparam logic [9:0]  Y_LIM   = 10'(V_ACTIVE);
  localparam logic [10:0] X_CELLS = 11'(MAP_N);
  localparam logic [9:0]  Y_CELLS = 10'(MAP_N);

  typedef enum logic [1:0] {
    SYNC   = 2'd0,
    ACTIVE = 2'd1,
    CHECK  = 2'd2
  } state_t;

  // True when every channel is at or above the threshold.
  function automatic logic all_at_least(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b, input logic [7:0] th);
    return (r >= th) && (g >= th) && (b >= th);
  endfunction

  // True when every channel is at or below the threshold.
  function automatic logic all_at_most(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b, input logic [7:0] th);
    return (r <= th) && (g <= th) && (b <= th);
  endfunction

  state_t               state_r;
  state_t               state_next_s;
  logic [10:0]          x_r;
  logic [9:0]           y_r;
  logic                 line_open_r;
  logic                 armed_r;
  logic                 first_frame_r;
  logic [N_CELLS-1:0]   shadow_state_r;
  logic [N_CELLS-1:0]   shadow_turn_r;
  logic [N_CELLS-1:0]   board_state_r;
  logic [N_CELLS-1:0]   turn_map_r;
  logic                 frame_valid_r;
  logic [15:0]          frame_cnt_r;

  logic                 vsync_fall_s;
  logic                 pix_en_s;
  logic                 line_end_s;
  logic [10:0]          x_off_s;
  logic [9:0]           y_off_s;
  logic [10:0]          col_s;
  logic [9:0]           row_s;
  logic                 sample_s;
  logic [K_W-1:0]       k_s;
  logic                 is_white_s;
  logic                 is_black_s;
  logic                 publish_s;

  // A frame boundary inside ACTIVE is a vsync low seen after vsync has been
  // high, so a long vsync pulse is treated as a single boundary.
  assign vsync_fall_s = (bus.vsync == 1'b0) && armed_r;

  // Pixels and line ends only count while vsync is high.
  assign pix_en_s   = (state_r == ACTIVE) && bus.vsync && bus.den;
  assign line_end_s = (state_r == ACTIVE) && bus.vsync && !bus.den && line_open_r;

  assign x_off_s = x_r - X_ORG;
  assign y_off_s = y_r - Y_ORG;
  assign col_s   = x_off_s / X_PITCH;
  assign row_s   = y_off_s / Y_PITCH;
  assign k_s     = K_W'(row_s) * K_W'(MAP_N) + K_W'(col_s);

  assign is_white_s = all_at_least(bus.R, bus.G, bus.B, WHI);
  assign is_black_s = all_at_most(bus.R, bus.G, bus.B, BLO);

  // Decide whether the current pixel is a grid-intersection sample.
  always_comb begin
    sample_s = 1'b0;
    if (pix_en_s && (x_r >= X_ORG) && (y_r >= Y_ORG) &&
        (x_r < X_LIM) && (y_r < Y_LIM) &&
        ((x_off_s % X_PITCH) == 11'd0) && ((y_off_s % Y_PITCH) == 10'd0) &&
        (col_s < X_CELLS) && (row_s < Y_CELLS)) begin
      sample_s = 1'b1;
    end else begin
      sample_s = 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= SYNC;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      SYNC: begin
        if (!bus.vsync) begin
          state_next_s = ACTIVE;
        end else begin
          state_next_s = SYNC;
        end
      end
      ACTIVE: begin
        if (vsync_fall_s) begin
          state_next_s = CHECK;
        end else begin
          state_next_s = ACTIVE;
        end
      end
      CHECK:   state_next_s = SYNC;
      default: state_next_s = SYNC;
    endcase
  end

`ifdef TFT_FRAME_DECODER_ERRCHK_EN
  logic bad_r;
  logic frame_err_r;
  logic err_sticky_r;
  logic reject_s;

  // Publish only complete, well-formed frames; the first frame after reset
  // is dropped silently because its start was not observed.
  always_comb begin
    publish_s = 1'b0;
    reject_s  = 1'b0;
    if ((state_r == CHECK) && !first_frame_r) begin
      if ((y_r == Y_LIM) && !bad_r) begin
        publish_s = 1'b1;
      end else begin
        reject_s = 1'b1;
      end
    end else begin
      publish_s = 1'b0;
      reject_s  = 1'b0;
    end
  end

  // Per-frame error tracking plus the frame_err pulse and sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad_r        <= 1'b0;
      frame_err_r  <= 1'b0;
      err_sticky_r <= 1'b0;
    end else begin
      frame_err_r <= 1'b0;
      case (state_r)
        SYNC: begin
          if (!bus.vsync) begin
            bad_r <= 1'b0;
          end
        end
        ACTIVE: begin
          if (line_end_s && ((x_r != X_LIM) || ((y_r + 10'd1) > Y_LIM))) begin
            bad_r <= 1'b1;
          end
        end
        CHECK: begin
          if (reject_s) begin
            frame_err_r  <= 1'b1;
            err_sticky_r <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.frame_err  = frame_err_r;
  assign bus.err_sticky = err_sticky_r;
`else
  // Without the checks every frame reaching CHECK is published, except the
  // first one after reset whose start was not observed.
  always_comb begin
    publish_s = 1'b0;
    if ((state_r == CHECK) && !first_frame_r) begin
      publish_s = 1'b1;
    end else begin
      publish_s = 1'b0;
    end
  end

  assign bus.frame_err  = 1'b0;
  assign bus.err_sticky = 1'b0;
`endif

  // Coordinate tracking, shadow capture and publication of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r            <= 11'd0;
      y_r            <= 10'd0;
      line_open_r    <= 1'b0;
      armed_r        <= 1'b0;
      first_frame_r  <= 1'b1;
      shadow_state_r <= {N_CELLS{1'b0}};
      shadow_turn_r  <= {N_CELLS{1'b0}};
      board_state_r  <= {N_CELLS{1'b0}};
      turn_map_r     <= {N_CELLS{1'b0}};
      frame_valid_r  <= 1'b0;
      frame_cnt_r    <= 16'd0;
    end else begin
      frame_valid_r <= 1'b0;
      case (state_r)
        SYNC: begin
          if (!bus.vsync) begin
            x_r            <= 11'd0;
            y_r            <= 10'd0;
            line_open_r    <= 1'b0;
            armed_r        <= 1'b0;
            shadow_state_r <= {N_CELLS{1'b0}};
            shadow_turn_r  <= {N_CELLS{1'b0}};
          end
        end
        ACTIVE: begin
          if (bus.vsync) begin
            armed_r <= 1'b1;
          end
          if (pix_en_s) begin
            x_r         <= x_r + 11'd1;
            line_open_r <= 1'b1;
          end
          if (line_end_s) begin
            x_r         <= 11'd0;
            y_r         <= y_r + 10'd1;
            line_open_r <= 1'b0;
          end
          if (sample_s) begin
            shadow_state_r[k_s] <= is_white_s || is_black_s;
            shadow_turn_r[k_s]  <= is_white_s;
          end
        end
        CHECK: begin
          first_frame_r <= 1'b0;
          if (publish_s) begin
            board_state_r <= shadow_state_r;
            turn_map_r    <= shadow_turn_r;
            frame_valid_r <= 1'b1;
            frame_cnt_r   <= frame_cnt_r + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.board_state = board_state_r;
  assign bus.turn_map    = turn_map_r;
  assign bus.frame_valid = frame_valid_r;
  assign bus.frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_tft_frame_decoder.sv
// Self-checking bench for tft_frame_decoder with a reduced raster
// (50x48 active pixels, 4-pixel pitch) so full frames stay short.
// Expected frame results are queued when each frame is driven and
// compared when frame_valid / frame_err pulses.
module tb_tft_frame_decoder;
  localparam int MAP_N = 10;
  localparam int N     = MAP_N * MAP_N;
  localparam int H_ACT = 50;
  localparam int V_ACT = 48;
  localparam int CX0   = 6;
  localparam int CY0   = 3;
  localparam int PITCH = 4;
  localparam int SOFF  = 1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  tft_frame_decoder_if #(.MAP_N(MAP_N)) bus ();

  tft_frame_decoder #(
    .MAP_N(MAP_N), .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .CX0(CX0), .CY0(CY0),
    .PITCH(PITCH), .SOFF(SOFF), .WHI(8'hC0), .BLO(8'h3F)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [N-1:0] bs;
    logic [N-1:0] tm;
    logic [15:0]  cnt;
    logic         is_err;
    logic         sticky;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [23:0]  cell_rgb [N];
  int           cell_cls [N];   // 0 empty, 1 black, 2 white
  logic [N-1:0] exp_bs;
  logic [N-1:0] exp_tm;
  logic [15:0]  exp_cnt;
  logic         exp_sticky;
  bit           skip_next;

  // Scoreboard: every output pulse must match the oldest queued frame.
  always @(negedge clk) begin
    exp_t e;
    if ((bus.frame_valid === 1'b1) || (bus.frame_err === 1'b1)) begin
      n_cmp++;
      if (bus.frame_valid && bus.frame_err) begin
        n_bad++;
        $display("FAIL pulse_excl: valid=%b err=%b, required only one", bus.frame_valid, bus.frame_err);
      end
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: valid=%b err=%b, required no pulse", bus.frame_valid, bus.frame_err);
      end else begin
        e = sb_q.pop_front();
        if (bus.frame_err !== e.is_err) begin
          n_bad++;
          $display("FAIL pulse_kind: err=%b, required err=%b", bus.frame_err, e.is_err);
        end
        n_cmp++;
        if (bus.board_state !== e.bs) begin
          n_bad++;
          $display("FAIL board_state: got %h, required %h", bus.board_state, e.bs);
        end
        n_cmp++;
        if (bus.turn_map !== e.tm) begin
          n_bad++;
          $display("FAIL turn_map: got %h, required %h", bus.turn_map, e.tm);
        end
        n_cmp++;
        if (bus.frame_cnt !== e.cnt) begin
          n_bad++;
          $display("FAIL frame_cnt: got %0d, required %0d", bus.frame_cnt, e.cnt);
        end
        n_cmp++;
        if (bus.err_sticky !== e.sticky) begin
          n_bad++;
          $display("FAIL err_sticky: got %b, required %b", bus.err_sticky, e.sticky);
        end
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #900000;
    $display("FAIL timeout: simulation exceeded its cycle budget");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_pix(input logic d, input logic [23:0] c);
    bus.den = d;
    bus.R   = c[23:16];
    bus.G   = c[15:8];
    bus.B   = c[7:0];
  endtask

  // Stone colour at intersections, alternating black/white elsewhere so a
  // misplaced sample point shows up as a wrong stone.
  function automatic logic [23:0] pix(input int x, input int y);
    logic [23:0] c;
    c = (((x + y) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
    for (int r = 0; r < MAP_N; r++) begin
      for (int q = 0; q < MAP_N; q++) begin
        if ((x == CX0 + SOFF + q * PITCH) && (y == CY0 + SOFF + r * PITCH)) begin
          c = cell_rgb[r * MAP_N + q];
        end
      end
    end
    return c;
  endfunction

  task automatic set_cell(input int k, input logic [23:0] c, input int cls);
    cell_rgb[k] = c;
    cell_cls[k] = cls;
  endtask

  task automatic clear_board();
    for (int k = 0; k < N; k++) set_cell(k, 24'hCD853F, 0);
  endtask

  task automatic random_board();
    int r;
    for (int k = 0; k < N; k++) begin
      r = $urandom_range(0, 2);
      if (r == 0) set_cell(k, 24'hCD853F, 0);
      else if (r == 1) set_cell(k, 24'h101010, 1);
      else set_cell(k, 24'hF0F0F0, 2);
    end
  endtask

  task automatic drive_lines(input int first, input int count, input int short_idx);
    int len;
    for (int l = first; l < first + count; l++) begin
      len = (l == short_idx) ? H_ACT - 1 : H_ACT;
      for (int x = 0; x < len; x++) begin
        bus.vsync = 1'b1;
        set_pix(1'b1, pix(x, l));
        tick();
      end
      set_pix(1'b0, 24'h000000);
      repeat (4) tick();
    end
  endtask

  task automatic vsync_pulse(input int len);
    for (int i = 0; i < len; i++) begin
      bus.vsync = 1'b0;
      set_pix(1'b0, 24'h000000);
      tick();
    end
    bus.vsync = 1'b1;
    repeat (3) tick();
  endtask

  // Drive the active part of a frame and queue what its CHECK must produce.
  task automatic send_frame(input int lines, input int short_idx);
    exp_t e;
    bit   err_exp;
    drive_lines(0, lines, short_idx);
    err_exp = 1'b0;
`ifdef TFT_FRAME_DECODER_ERRCHK_EN
    err_exp = (lines != V_ACT) || ((short_idx >= 0) && (short_idx < lines));
`endif
    if (skip_next) begin
      skip_next = 1'b0;
    end else if (err_exp) begin
      exp_sticky = 1'b1;
      e.bs = exp_bs; e.tm = exp_tm; e.cnt = exp_cnt; e.is_err = 1'b1; e.sticky = 1'b1;
      sb_q.push_back(e);
    end else begin
      for (int k = 0; k < N; k++) begin
        exp_bs[k] = (cell_cls[k] != 0);
        exp_tm[k] = (cell_cls[k] == 2);
      end
      exp_cnt = exp_cnt + 16'd1;
      e.bs = exp_bs; e.tm = exp_tm; e.cnt = exp_cnt; e.is_err = 1'b0; e.sticky = exp_sticky;
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) tick();
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d frames still pending, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic model_reset();
    exp_bs = '0; exp_tm = '0; exp_cnt = 16'd0; exp_sticky = 1'b0; skip_next = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if (bus.board_state !== '0) begin n_bad++; $display("FAIL %s board_state: got %h, required 0", tag, bus.board_state); end
    n_cmp++;
    if (bus.turn_map !== '0) begin n_bad++; $display("FAIL %s turn_map: got %h, required 0", tag, bus.turn_map); end
    n_cmp++;
    if (bus.frame_cnt !== 16'd0) begin n_bad++; $display("FAIL %s frame_cnt: got %0d, required 0", tag, bus.frame_cnt); end
    n_cmp++;
    if (bus.frame_valid !== 1'b0) begin n_bad++; $display("FAIL %s frame_valid: got %b, required 0", tag, bus.frame_valid); end
    n_cmp++;
    if (bus.frame_err !== 1'b0) begin n_bad++; $display("FAIL %s frame_err: got %b, required 0", tag, bus.frame_err); end
    n_cmp++;
    if (bus.err_sticky !== 1'b0) begin n_bad++; $display("FAIL %s err_sticky: got %b, required 0", tag, bus.err_sticky); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.vsync = 1'b1;
    set_pix(1'b0, 24'h000000);
    model_reset();
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_empty();
    clear_board();
    vsync_pulse(3);
    send_frame(V_ACT, -1);   // first frame after reset: dropped silently
    vsync_pulse(3);
    send_frame(V_ACT, -1);
    vsync_pulse(3);
    wait_drain();
    n_cmp++;
    if (bus.frame_cnt !== 16'd1) begin n_bad++; $display("FAIL empty frame_cnt: got %0d, required 1", bus.frame_cnt); end
  endtask

  task automatic test_stones();
    clear_board();
    set_cell(0,  24'h000000, 1);
    set_cell(44, 24'hFFFFFF, 2);
    set_cell(9,  24'h3F3F3F, 1);   // black at threshold
    set_cell(99, 24'hC0C0C0, 2);   // white at threshold
    set_cell(90, 24'hC0C0BF, 0);   // one channel under white
    set_cell(55, 24'h400000, 0);   // one channel over black
    set_cell(11, 24'h3F3F40, 0);
    send_frame(V_ACT, -1);
    vsync_pulse(3);
    wait_drain();
    n_cmp++;
    if ({bus.board_state[44], bus.turn_map[44], bus.board_state[0], bus.turn_map[0]} !== 4'b1110) begin
      n_bad++;
      $display("FAIL stones k44/k0: got %b%b%b%b, required 1110",
               bus.board_state[44], bus.turn_map[44], bus.board_state[0], bus.turn_map[0]);
    end
  endtask

  task automatic test_random();
    random_board();
    send_frame(V_ACT, -1);
    vsync_pulse(3);
    wait_drain();
  endtask

  task automatic test_short_line();
    random_board();
    send_frame(V_ACT, 10);
    vsync_pulse(3);
    wait_drain();
    n_cmp++;
    if (bus.err_sticky !== exp_sticky) begin n_bad++; $display("FAIL short sticky: got %b, required %b", bus.err_sticky, exp_sticky); end
  endtask

  task automatic test_long_frame();
    random_board();
    send_frame(V_ACT + 1, -1);
    vsync_pulse(3);
    random_board();
    send_frame(V_ACT, -1);
    vsync_pulse(3);
    wait_drain();
  endtask

  task automatic test_mid_reset();
    random_board();
    drive_lines(0, 20, -1);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    tick();
    rst = 1'b0;
    model_reset();
    drive_lines(20, V_ACT - 20, -1);
    vsync_pulse(3);
    send_frame(V_ACT, -1);   // first full frame after reset: not published
    vsync_pulse(3);
    random_board();
    send_frame(V_ACT, -1);
    vsync_pulse(3);
    wait_drain();
  endtask

  task automatic test_long_vsync();
    int hits;
    int pos;
    random_board();
    send_frame(V_ACT, -1);
    hits = 0;
    pos  = 0;
    for (int i = 1; i <= 10; i++) begin
      bus.vsync = 1'b0;
      set_pix(1'b1, 24'hFFFFFF);   // den during vsync must be ignored
      tick();
      if (bus.frame_valid === 1'b1) begin
        hits++;
        pos = i;
      end
    end
    n_cmp++;
    if ((hits != 1) || (pos != 2)) begin
      n_bad++;
      $display("FAIL long_vsync: %0d pulses at cycle %0d, required 1 pulse at cycle 2", hits, pos);
    end
    bus.vsync = 1'b1;
    set_pix(1'b0, 24'h000000);
    repeat (3) tick();
    random_board();
    send_frame(V_ACT, -1);
    vsync_pulse(3);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_empty();
    test_stones();
    test_random();
    test_short_line();
    test_long_frame();
    test_mid_reset();
    test_long_vsync();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
